// File: rtl/fpu_div_out_pack.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : fpu_div_out_pack                                            |
// | Description : Divide-pipe back end. Clamps the 13-bit divide exponent,    |
// |               packs sign/exponent/fraction into an IEEE single or double  |
// |               word and queues it, with tag, flags and precision, in a     |
// |               2-entry FIFO drained by the output arbiter (req/gnt).       |
// |               Stall is raised while the FIFO is full; a push that finds   |
// |               no room is lost and flagged by a sticky drop error.         |
// | Ports       : rclk, arst              clock, async active-high reset      |
// |               d8stg_*, div_*_out,     push side (valid, precision, tag,   |
// |               div_exc                 sign, exponent, fraction, flags)    |
// |               div_out_gnt             arbiter grant (pop)                 |
// |               div_out_req/data/id/    FIFO head and non-empty request     |
// |               exc/dbl                                                     |
// |               div_out_stall           FIFO full                           |
// |               div_out_drop_err        sticky lost-push indicator          |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module fpu_div_out_pack #(
  parameter int ID_W  = 10,
  parameter int DEPTH = 2
) (
  input  logic            rclk,
  input  logic            arst,
  input  logic            d8stg_fdiv,
  input  logic            d8stg_fdivd,
  input  logic [ID_W-1:0] d8stg_id,
  input  logic            div_sign_out,
  input  logic [12:0]     div_exp_out,
  input  logic [51:0]     div_frac_out,
  input  logic [4:0]      div_exc,
  input  logic            div_out_gnt,
  output logic            div_out_req,
  output logic [63:0]     div_out_data,
  output logic [ID_W-1:0] div_out_id,
  output logic [4:0]      div_out_exc,
  output logic            div_out_dbl,
  output logic            div_out_stall,
  output logic            div_out_drop_err
);

  // Count is 2 bits and pointers are 1 bit, so only a depth of 2 is meaningful.
  localparam logic [1:0] c_full = 2'(DEPTH);

  logic [63:0]     r_data [DEPTH];
  logic [ID_W-1:0] r_id   [DEPTH];
  logic [4:0]      r_exc  [DEPTH];
  logic            r_dbl  [DEPTH];
  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic            r_drop_err;

  logic [10:0]     w_exp_dbl;
  logic [7:0]      w_exp_sgl;
  logic [63:0]     w_packed;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // Exponent clamp: bit 12 marks a negative (underflowed) exponent, bit 11 an
  // overflow; both saturate the field, the flags are left untouched.
  always_comb begin
    w_exp_dbl = div_exp_out[10:0];
    w_exp_sgl = div_exp_out[7:0];
    if (div_exp_out[12]) begin
      w_exp_dbl = 11'h000;
      w_exp_sgl = 8'h00;
    end else if (div_exp_out[11]) begin
      w_exp_dbl = 11'h7FF;
      w_exp_sgl = 8'hFF;
    end
  end

  // Single results occupy the upper word; the lower word is zero.
  always_comb begin
    if (d8stg_fdivd) begin
      w_packed = {div_sign_out, w_exp_dbl, div_frac_out};
    end else begin
      w_packed = {div_sign_out, w_exp_sgl, div_frac_out[51:29], 32'h0000_0000};
    end
  end

  assign w_full = (r_count == c_full);
  assign w_pop  = div_out_req & div_out_gnt;
  // A full FIFO still accepts a push when its head leaves in the same cycle;
  // the write lands on the slot being vacated (wr_ptr == rd_ptr when full).
  assign w_push = d8stg_fdiv & (~w_full | w_pop);
  assign w_drop = d8stg_fdiv & w_full & ~w_pop;

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_drop_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_id[i]   <= '0;
        r_exc[i]  <= '0;
        r_dbl[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_packed;
        r_id[r_wr_ptr]   <= d8stg_id;
        r_exc[r_wr_ptr]  <= div_exc;
        r_dbl[r_wr_ptr]  <= d8stg_fdivd;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  // Head outputs are a pointer-selected read of storage flops only; gnt does
  // not reach them combinationally.
  assign div_out_req      = (r_count != 2'd0);
  assign div_out_stall    = w_full;
  assign div_out_drop_err = r_drop_err;
  assign div_out_data     = r_data[r_rd_ptr];
  assign div_out_id       = r_id[r_rd_ptr];
  assign div_out_exc      = r_exc[r_rd_ptr];
  assign div_out_dbl      = r_dbl[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_out_pack.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_fpu_div_out_pack                                         |
// | Description : Self-checking bench for fpu_div_out_pack. Expected entries  |
// |               are queued when a push is accepted by the bench's own       |
// |               occupancy model and compared when they reach the FIFO head. |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module tb_fpu_div_out_pack;

  localparam int ID_W = 10;

  typedef struct packed {
    logic [63:0]     data;
    logic [ID_W-1:0] id;
    logic [4:0]      exc;
    logic            dbl;
  } ent_t;

  logic            rclk = 1'b0;
  logic            arst;
  logic            d8stg_fdiv;
  logic            d8stg_fdivd;
  logic [ID_W-1:0] d8stg_id;
  logic            div_sign_out;
  logic [12:0]     div_exp_out;
  logic [51:0]     div_frac_out;
  logic [4:0]      div_exc;
  logic            div_out_gnt;
  logic            div_out_req;
  logic [63:0]     div_out_data;
  logic [ID_W-1:0] div_out_id;
  logic [4:0]      div_out_exc;
  logic            div_out_dbl;
  logic            div_out_stall;
  logic            div_out_drop_err;

  ent_t q[$];
  bit   m_drop;
  int   n_chk;
  int   n_pass;

  fpu_div_out_pack #(.ID_W(ID_W), .DEPTH(2)) dut (
    .rclk             (rclk),
    .arst             (arst),
    .d8stg_fdiv       (d8stg_fdiv),
    .d8stg_fdivd      (d8stg_fdivd),
    .d8stg_id         (d8stg_id),
    .div_sign_out     (div_sign_out),
    .div_exp_out      (div_exp_out),
    .div_frac_out     (div_frac_out),
    .div_exc          (div_exc),
    .div_out_gnt      (div_out_gnt),
    .div_out_req      (div_out_req),
    .div_out_data     (div_out_data),
    .div_out_id       (div_out_id),
    .div_out_exc      (div_out_exc),
    .div_out_dbl      (div_out_dbl),
    .div_out_stall    (div_out_stall),
    .div_out_drop_err (div_out_drop_err)
  );

  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference packing written from the IEEE field layout.
  function automatic logic [63:0] pack(input logic s, input logic [12:0] e,
                                       input logic [51:0] f, input logic d);
    logic [10:0] ef;
    if (e[12])      ef = 11'h000;
    else if (e[11]) ef = d ? 11'h7FF : 11'h0FF;
    else            ef = d ? e[10:0] : {3'b000, e[7:0]};
    if (d) return {s, ef, f};
    return {s, ef[7:0], f[51:29], 32'h0};
  endfunction

  task automatic drive(input logic v, input logic d, input logic [ID_W-1:0] id,
                       input logic s, input logic [12:0] e, input logic [51:0] f,
                       input logic [4:0] x, input logic g);
    d8stg_fdiv   = v;
    d8stg_fdivd  = d;
    d8stg_id     = id;
    div_sign_out = s;
    div_exp_out  = e;
    div_frac_out = f;
    div_exc      = x;
    div_out_gnt  = g;
  endtask

  // Advances one clock, updating the scoreboard from the bench's own view of
  // occupancy, then lets outputs settle 1 time unit past the edge.
  task automatic tick();
    bit   pop;
    bit   acc;
    ent_t e;
    pop    = div_out_gnt && (q.size() != 0);
    acc    = d8stg_fdiv && ((q.size() < 2) || pop);
    e.data = pack(div_sign_out, div_exp_out, div_frac_out, d8stg_fdivd);
    e.id   = d8stg_id;
    e.exc  = div_exc;
    e.dbl  = d8stg_fdivd;
    @(posedge rclk);
    if (pop) q.delete(0);
    if (acc) q.push_back(e);
    if (d8stg_fdiv && !acc) m_drop = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge rclk);
    #1;
    n_chk++;
    if (div_out_req !== 1'b0 || div_out_stall !== 1'b0 || div_out_drop_err !== 1'b0)
      $display("FAIL reset_flags got req=%0b stall=%0b drop=%0b want 0 0 0",
               div_out_req, div_out_stall, div_out_drop_err);
    else n_pass++;
    n_chk++;
    if (div_out_data !== 64'h0 || div_out_id !== '0 || div_out_exc !== 5'h0 || div_out_dbl !== 1'b0)
      $display("FAIL reset_head got data=%h id=%0d exc=%h dbl=%0b want all 0",
               div_out_data, div_out_id, div_out_exc, div_out_dbl);
    else n_pass++;
    arst = 1'b0;
    q.delete();
    m_drop = 1'b0;
  endtask

  task automatic test_double_push();
    drive(1'b1, 1'b1, 10'd5, 1'b0, 13'h03FF, 52'h0, 5'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    n_chk++;
    if (div_out_req !== 1'b1) $display("FAIL dbl_req got %0b want 1", div_out_req);
    else n_pass++;
    n_chk++;
    if (div_out_data !== 64'h3FF0_0000_0000_0000 || div_out_id !== 10'd5 || div_out_dbl !== 1'b1)
      $display("FAIL dbl_head got data=%h id=%0d dbl=%0b want 3ff0000000000000 5 1",
               div_out_data, div_out_id, div_out_dbl);
    else n_pass++;
    tick();
    n_chk++;
    if (div_out_req !== 1'b0) $display("FAIL dbl_req_after_pop got %0b want 0", div_out_req);
    else n_pass++;
  endtask

  task automatic test_single_push();
    drive(1'b1, 1'b0, 10'd9, 1'b1, 13'h007F, {23'h400000, 29'h0}, 5'h01, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    n_chk++;
    if (div_out_data !== 64'hBFC0_0000_0000_0000 || div_out_dbl !== 1'b0 || div_out_exc !== 5'h01)
      $display("FAIL sgl_head got data=%h dbl=%0b exc=%h want bfc0000000000000 0 01",
               div_out_data, div_out_dbl, div_out_exc);
    else n_pass++;
    tick();
  endtask

  task automatic test_clamp();
    drive(1'b1, 1'b1, 10'd11, 1'b0, 13'h1805, 52'h0_0000_0000_1234, 5'h06, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    n_chk++;
    if (div_out_data !== 64'h0000_0000_0000_1234 || div_out_exc !== 5'h06)
      $display("FAIL clamp_neg got data=%h exc=%h want 0000000000001234 06",
               div_out_data, div_out_exc);
    else n_pass++;
    tick();
    drive(1'b1, 1'b0, 10'd12, 1'b0, 13'h0805, 52'h0, 5'h09, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    n_chk++;
    if (div_out_data[62:55] !== 8'hFF || div_out_data !== q[0].data || div_out_exc !== 5'h09)
      $display("FAIL clamp_ovf got data=%h exc=%h want %h 09",
               div_out_data, div_out_exc, q[0].data);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 10'(i), 1'b0, 13'(12'h400 + i), 52'(i), 5'h00, 1'b0);
      tick();
      if (i == 2) begin
        n_chk++;
        if (div_out_stall !== 1'b1 || div_out_drop_err !== 1'b0)
          $display("FAIL bp_stall got stall=%0b drop=%0b want 1 0", div_out_stall, div_out_drop_err);
        else n_pass++;
      end
    end
    n_chk++;
    if (div_out_drop_err !== 1'b1 || div_out_stall !== 1'b1 || div_out_id !== 10'd1)
      $display("FAIL bp_drop got drop=%0b stall=%0b id=%0d want 1 1 1",
               div_out_drop_err, div_out_stall, div_out_id);
    else n_pass++;
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 1; i <= 2; i++) begin
      n_chk++;
      if (div_out_req !== 1'b1 || {div_out_data, div_out_id, div_out_exc, div_out_dbl} !== q[0] ||
          div_out_id !== 10'(i))
        $display("FAIL bp_drain%0d got req=%0b id=%0d data=%h want 1 %0d %h",
                 i, div_out_req, div_out_id, div_out_data, i, q[0].data);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (div_out_req !== 1'b0 || div_out_stall !== 1'b0 || div_out_drop_err !== 1'b1)
      $display("FAIL bp_empty got req=%0b stall=%0b drop=%0b want 0 0 1",
               div_out_req, div_out_stall, div_out_drop_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 10'd21, 1'b0, 13'h0123, 52'h5, 5'h00, 1'b0);
    tick();
    drive(1'b1, 1'b1, 10'd22, 1'b0, 13'h0124, 52'h6, 5'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    arst = 1'b1;
    #1;
    n_chk++;
    if (div_out_req !== 1'b0 || div_out_stall !== 1'b0 || div_out_drop_err !== 1'b0 || div_out_id !== '0)
      $display("FAIL rstmid_flags got req=%0b stall=%0b drop=%0b id=%0d want 0 0 0 0",
               div_out_req, div_out_stall, div_out_drop_err, div_out_id);
    else n_pass++;
    #1;
    arst = 1'b0;
    q.delete();
    m_drop = 1'b0;
    test_double_push();
  endtask

  task automatic test_full_simul();
    drive(1'b1, 1'b0, 10'd4, 1'b0, 13'h0081, 52'h0, 5'h10, 1'b0);
    tick();
    drive(1'b1, 1'b1, 10'd5, 1'b1, 13'h0401, 52'h3, 5'h02, 1'b0);
    tick();
    drive(1'b1, 1'b1, 10'd7, 1'b0, 13'h0402, 52'h7, 5'h04, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    n_chk++;
    if (div_out_stall !== 1'b1 || div_out_drop_err !== 1'b0 || div_out_id !== 10'd5)
      $display("FAIL full_simul got stall=%0b drop=%0b id=%0d want 1 0 5",
               div_out_stall, div_out_drop_err, div_out_id);
    else n_pass++;
    tick();
    n_chk++;
    if (div_out_req !== 1'b1 || {div_out_data, div_out_id, div_out_exc, div_out_dbl} !== q[0] ||
        div_out_id !== 10'd7)
      $display("FAIL full_simul_next got req=%0b id=%0d data=%h want 1 7 %h",
               div_out_req, div_out_id, div_out_data, q[0].data);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom),
            1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
            {20'($urandom), 32'($urandom)}, 5'($urandom), 1'($urandom_range(0, 2) != 0));
      n_chk++;
      if (div_out_req !== (q.size() != 0) || div_out_stall !== (q.size() == 2) ||
          div_out_drop_err !== m_drop)
        $display("FAIL b2b_flags cyc%0d got req=%0b stall=%0b drop=%0b want %0b %0b %0b",
                 c, div_out_req, div_out_stall, div_out_drop_err,
                 q.size() != 0, q.size() == 2, m_drop);
      else n_pass++;
      if (q.size() != 0) begin
        n_chk++;
        if ({div_out_data, div_out_id, div_out_exc, div_out_dbl} !== q[0])
          $display("FAIL b2b_head cyc%0d got data=%h id=%0d exc=%h dbl=%0b want %h %0d %h %0b",
                   c, div_out_data, div_out_id, div_out_exc, div_out_dbl,
                   q[0].data, q[0].id, q[0].exc, q[0].dbl);
        else n_pass++;
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    repeat (3) tick();
    n_chk++;
    if (div_out_req !== 1'b0 || q.size() != 0)
      $display("FAIL b2b_drain got req=%0b want 0", div_out_req);
    else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_drop = 1'b0;
    test_reset();
    @(negedge rclk);
    test_double_push();
    test_single_push();
    test_clamp();
    test_backpressure();
    test_reset_mid();
    test_full_simul();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_div_out_pack.md
Name: fpu_div_out_pack

Overview:
Back end of the divide pipe. It takes the final divide exponent (13-bit, with underflow and overflow guard bits), the fraction, the sign and the exception flags. It packs them into an IEEE single or double result word and holds that result in a 2-entry FIFO. The FIFO is drained by the FPU output arbiter through a req/gnt handshake, and the block tells the divide pipe to stall when the FIFO is full.

Parameters:
ID_W, 10, width of the request tag carried with each result
DEPTH, 2, result FIFO entries; only 2 is supported, and the count is 2 bits wide

Ports:
rclk  input  1  global clock
arst  input  1  asynchronous reset, active high
d8stg_fdiv  input  1  divide result valid this cycle (push)
d8stg_fdivd  input  1  1 = double, 0 = single
d8stg_id  input  ID_W  request tag
div_sign_out  input  1  result sign
div_exp_out  input  13  biased result exponent; [12] = negative, [11] = overflow guard
div_frac_out  input  52  result fraction; single uses [51:29]
div_exc  input  5  {nv, of, uf, dz, nx}
div_out_gnt  input  1  arbiter grant (pop)
div_out_req  output  1  FIFO non-empty
div_out_data  output  64  packed result at FIFO head
div_out_id  output  ID_W  tag at head
div_out_exc  output  5  exception flags at head
div_out_dbl  output  1  precision at head
div_out_stall  output  1  FIFO full; the divide pipe must hold
div_out_drop_err  output  1  sticky: a push arrived while full and was lost

Behaviour:
- Reset (arst high, takes effect asynchronously):
  - FIFO count = 0; read and write pointers = 0.
  - div_out_req = 0, div_out_stall = 0, div_out_drop_err = 0.
  - All entry storage = 0, so div_out_data/id/exc/dbl read 0.
  - Reset mid-transfer discards all entries with no partial pop.
- Exponent clamp, combinational on the push path:
  - exp[12] = 1: exponent field = 0 (denormal or zero).
  - Else exp[11] = 1: exponent field = all ones (0x7FF double, 0xFF single).
  - Else double uses exp[10:0]; single uses exp[7:0].
  - The clamp never modifies the flags; div_exc passes through unchanged.
- Packing:
  - Double: data = {sign, exp11, frac[51:0]}.
  - Single: data[63:32] = {sign, exp8, frac[51:29]}; data[31:0] = 0.
- Push: when d8stg_fdiv = 1 and there is room, the entry is written at the write pointer on the clock edge. Room means count < 2, or count = 2 with a pop in the same cycle.
- Pop: when div_out_req = 1 and div_out_gnt = 1, the read pointer advances at the edge. A gnt while req = 0 is ignored.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at count 1 and at count 2.
- Latency: a push in cycle N gives req = 1 and valid head data in cycle N+1. All outputs come from flops or FIFO storage; there is no combinational path from gnt to data.
- Handshake: while req = 1 and gnt = 0, data, id, exc and dbl are held stable.
- div_out_stall = (count == 2). It is registered state and does not depend on gnt in the same cycle.
- Push with count = 2 and no pop: the entry is dropped, count stays 2, and div_out_drop_err is set. It clears only on arst.
- Pointers are 1 bit each and wrap modulo 2.

Test Plan:
- Double push: sign = 0, exp = 0x3FF, frac = 0, id = 5, gnt held 1 → next cycle req = 1, data = 0x3FF0000000000000, id = 5, dbl = 1; the following cycle req = 0.
- Single push: sign = 1, exp = 0x07F, frac[51:29] = 0x400000 → data = 0xBFC0000000000000.
- Clamp cases:
  - exp = 0x1805 (bit 12 set), double → exponent field = 0.
  - exp = 0x0805 (bit 11 set), single → data[62:55] = 0xFF.
  - In both cases div_out_exc equals div_exc.
- Backpressure: gnt = 0, three pushes with ids 1, 2, 3 → stall = 1 after the 2nd push; id 3 is dropped and drop_err = 1. Raising gnt for 2 cycles then yields ids 1 and 2 in order, after which req = 0 and stall = 0.
- Full with simultaneous events: count = 2, push id 7 with gnt = 1 in the same cycle → head pops, id 7 is accepted, count stays 2, drop_err stays 0.
- Reset mid-operation: with 2 entries queued, pulse arst between clock edges → req, stall and drop_err go to 0 immediately; a later push behaves as in the first scenario.
